gpio_flicker_host: RTL and testbench
====================================

GPIO_FLICKER_HOST -- requirements
Module: gpio_flicker_host

Interface
REQ-001 Parameter: FIFO_DEPTH, default 16, number of receive-buffer entries (power of two).
REQ-002 Parameter: TIMEOUT, default 65535, max cycles spent waiting on any single device edge.
REQ-003 Port: clk  in  1  single clock for all logic.
REQ-004 Port: rst_n  in  1  reset, asynchronous and active-low.
REQ-005 Port: cmd_valid  in  1  host requests a range transfer.
REQ-006 Port: cmd_ready  out  1  high only in IDLE.
REQ-007 Port: cmd_start  in  8  range start, sampled on accept.
REQ-008 Port: cmd_end  in  8  range end, sampled on accept.
REQ-009 Port: gpio_in_o  out  32  drives the device GPIO inputs: [9] write flicker, [8] read flicker, [7:0] data, [31:10] zero.
REQ-010 Port: gpio_out_i  in  32  device GPIO outputs: [9] device write flicker (pw), [8] device read flicker (pr), [7:0] device data; [31:10] ignored.
REQ-011 Port: rd_valid  out  1  FIFO not empty.
REQ-012 Port: rd_data  out  8  FIFO head, show-ahead.
REQ-013 Port: rd_en  in  1  pop when rd_valid high.
REQ-014 Port: busy  out  1  FSM not in IDLE.
REQ-015 Port: done  out  1  one-cycle pulse on successful transfer completion.
REQ-016 Port: err  out  1  sticky timeout flag.

Function
REQ-017 gpio_out_i[9:8] SHALL pass through a 2-flop synchronizer; pw/pr below denote synchronized values; data [7:0] sampled unsynchronized, only while synchronized pw is high.
REQ-018 Accept when cmd_valid && cmd_ready; latch start/end; expected count N = (end > start) ? end - start : 0 (8-bit); clear err.
REQ-019 States: IDLE, SEND_A_HI, SEND_A_LO, SEND_B_HI, SEND_B_LO, RECV_WAIT, RECV_ACK.
REQ-020 SEND_A_HI: data=start, write flicker=1; on pr=1 -> SEND_A_LO.
REQ-021 SEND_A_LO: write flicker=0, data held; on pr=0 -> SEND_B_HI.
REQ-022 SEND_B_HI: data=end, write flicker=1; on pr=1 -> SEND_B_LO.
REQ-023 SEND_B_LO: write flicker=0; on pr=0 -> RECV_WAIT if N>0, else IDLE with done pulse.
REQ-024 RECV_WAIT: read flicker=0; on pw=1 and FIFO not full, push gpio_out_i[7:0] and -> RECV_ACK; on pw=1 with FIFO full, stay (backpressure, no push, no data loss).
REQ-025 RECV_ACK: read flicker=1; on pw=0, decrement N, read flicker=0 next cycle; -> RECV_WAIT if N>0, else IDLE with done pulse.
REQ-026 Exactly one push per device byte; no push in any other state.
REQ-027 Timeout counter clears on every state change; counts in SEND_*/RECV_ACK, and in RECV_WAIT only while FIFO not full; reaching TIMEOUT -> err=1, both flickers 0, -> IDLE, no done pulse; FIFO contents retained.
REQ-028 cmd_valid while busy SHALL be ignored (cmd_ready low).
REQ-029 FIFO: simultaneous push and pop permitted when non-empty; pop with rd_valid low ignored; pointers wrap modulo FIFO_DEPTH.
REQ-030 gpio_in_o[31:10] SHALL always be zero; data [7:0] zero in IDLE and RECV_*.

Reset
REQ-031 On rst_n low, immediately: state IDLE, gpio_in_o=0, FIFO empty (rd_valid=0, rd_data=0), busy=0, done=0, err=0, N=0, timeout counter 0, synchronizers 0.
REQ-032 Reset mid-transfer SHALL abort without further push; device must be reset concurrently.

Verification
REQ-033 start=3,end=7 against device model -> FIFO receives 3,4,5,6; done pulses once; busy low after.
REQ-034 start=end=5 -> two send handshakes, zero pushes, done pulses after SEND_B_LO.
REQ-035 start=0,end=20, rd_en low -> 16 pushes, read flicker stays 0 while full, no err; drain -> remaining 4 bytes 16..19 in order.
REQ-036 TIMEOUT=100, device silent -> err=1 after 100 cycles in SEND_A_HI, gpio_in_o=0, IDLE, no done; next command clears err.
REQ-037 rst_n asserted in RECV_ACK -> all outputs zero same cycle, FIFO empty.
REQ-038 cmd_valid pulsed while busy -> ignored; current transfer completes unchanged.

Source files
------------

// File: rtl/gpio_flicker_host.sv
// ============================================================================
//  Module      : gpio_flicker_host
//  Description : Host side of a two-flicker GPIO handshake. Sends a start/end
//                byte pair, then buffers the returned byte stream in a FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_flicker_host #(
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_start,
  input  logic [7:0]  cmd_end,
  output logic [31:0] gpio_in_o,
  input  logic [31:0] gpio_out_i,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  input  logic        rd_en,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int              C_AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              C_TW   = $clog2(TIMEOUT + 1);
  localparam logic [C_TW-1:0] C_TLIM = C_TW'(TIMEOUT - 1);
  localparam logic [C_AW:0]   C_FULL = (C_AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SEND_A_HI = 3'd1,
    S_SEND_A_LO = 3'd2,
    S_SEND_B_HI = 3'd3,
    S_SEND_B_LO = 3'd4,
    S_RECV_WAIT = 3'd5,
    S_RECV_ACK  = 3'd6
  } state_t;

  state_t          r_state;
  logic [1:0]      r_sync1;
  logic [1:0]      r_sync2;
  logic [7:0]      r_end;
  logic [7:0]      r_n;
  logic [C_TW-1:0] r_tcnt;
  logic            r_wflk;
  logic            r_rflk;
  logic [7:0]      r_data;
  logic            r_done;
  logic            r_err;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [C_AW-1:0] r_wptr;
  logic [C_AW-1:0] r_rptr;
  logic [C_AW:0]   r_count;

  logic w_pw;
  logic w_pr;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_adv;
  logic w_count_en;
  logic w_tmo;
  logic w_unused;

  assign w_pw     = r_sync2[1];
  assign w_pr     = r_sync2[0];
  assign w_full   = (r_count == C_FULL);
  assign w_empty  = (r_count == '0);
  assign w_unused = &{1'b0, gpio_out_i[31:10]};

  // w_adv is the progress condition of the current state; every advance is a state change.
  always_comb begin
    w_adv = 1'b0;
    case (r_state)
      S_SEND_A_HI: w_adv = w_pr;
      S_SEND_A_LO: w_adv = !w_pr;
      S_SEND_B_HI: w_adv = w_pr;
      S_SEND_B_LO: w_adv = !w_pr;
      S_RECV_WAIT: w_adv = w_pw && !w_full;
      S_RECV_ACK:  w_adv = !w_pw;
      default:     w_adv = 1'b0;
    endcase
  end

  assign w_count_en = (r_state != S_IDLE) && !((r_state == S_RECV_WAIT) && w_full);
  assign w_tmo      = w_count_en && (r_tcnt == C_TLIM);
  assign w_push     = (r_state == S_RECV_WAIT) && w_adv;
  assign w_pop      = rd_en && !w_empty;

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign err       = r_err;
  assign gpio_in_o = {22'd0, r_wflk, r_rflk, r_data};
  assign rd_valid  = !w_empty;
  assign rd_data   = w_empty ? 8'd0 : r_mem[r_rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_end   <= '0;
      r_n     <= '0;
      r_tcnt  <= '0;
      r_wflk  <= 1'b0;
      r_rflk  <= 1'b0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_sync1 <= gpio_out_i[9:8];
      r_sync2 <= r_sync1;
      r_done  <= 1'b0;
      if (w_adv) begin
        r_tcnt <= '0;
      end else if (w_count_en) begin
        r_tcnt <= r_tcnt + 1'b1;
      end

      if (w_tmo && !w_adv) begin
        r_state <= S_IDLE;
        r_err   <= 1'b1;
        r_wflk  <= 1'b0;
        r_rflk  <= 1'b0;
        r_data  <= '0;
        r_tcnt  <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (cmd_valid) begin
              r_end   <= cmd_end;
              r_n     <= (cmd_end > cmd_start) ? (cmd_end - cmd_start) : 8'd0;
              r_err   <= 1'b0;
              r_data  <= cmd_start;
              r_wflk  <= 1'b1;
              r_state <= S_SEND_A_HI;
            end
          end
          S_SEND_A_HI: begin
            if (w_pr) begin
              r_wflk  <= 1'b0;
              r_state <= S_SEND_A_LO;
            end
          end
          S_SEND_A_LO: begin
            if (!w_pr) begin
              r_data  <= r_end;
              r_wflk  <= 1'b1;
              r_state <= S_SEND_B_HI;
            end
          end
          S_SEND_B_HI: begin
            if (w_pr) begin
              r_wflk  <= 1'b0;
              r_state <= S_SEND_B_LO;
            end
          end
          S_SEND_B_LO: begin
            if (!w_pr) begin
              r_data <= '0;
              if (r_n != 8'd0) begin
                r_state <= S_RECV_WAIT;
              end else begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
              end
            end
          end
          S_RECV_WAIT: begin
            if (w_adv) begin
              r_rflk  <= 1'b1;
              r_state <= S_RECV_ACK;
            end
          end
          S_RECV_ACK: begin
            if (!w_pw) begin
              r_rflk <= 1'b0;
              r_n    <= r_n - 8'd1;
              if (r_n == 8'd1) begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_RECV_WAIT;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Payload storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= gpio_out_i[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gpio_flicker_host.sv
// ============================================================================
//  Module      : tb_gpio_flicker_host
//  Description : Directed self-checking bench for gpio_flicker_host with a
//                behavioural flicker-protocol device model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpio_flicker_host;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_start;
  logic [7:0]  cmd_end;
  logic [31:0] gpio_in_o;
  logic [31:0] gpio_out_i;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        rd_en;
  logic        busy;
  logic        done;
  logic        err;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  logic       dev_en;
  logic       dev_pw;
  logic       dev_pr;
  logic [7:0] dev_data;
  logic [7:0] dev_a;
  logic [7:0] dev_b;
  logic [7:0] dev_cur;
  int         dstate;

  always #5 clk = ~clk;

  gpio_flicker_host #(
    .FIFO_DEPTH (16),
    .TIMEOUT    (100)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_start  (cmd_start),
    .cmd_end    (cmd_end),
    .gpio_in_o  (gpio_in_o),
    .gpio_out_i (gpio_out_i),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_en      (rd_en),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // Upper bits carry junk the host must ignore.
  assign gpio_out_i = {22'h2AAAAA, dev_pw, dev_pr, dev_data};

  // Device: acknowledges two written bytes, then returns bytes start..end-1.
  initial begin
    dev_pw = 1'b0; dev_pr = 1'b0; dev_data = 8'd0;
    dev_a = 8'd0; dev_b = 8'd0; dev_cur = 8'd0; dstate = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1 || !dev_en) begin
        dev_pw = 1'b0; dev_pr = 1'b0; dev_data = 8'd0; dstate = 0;
      end else begin
        case (dstate)
          0: if (gpio_in_o[9]) begin dev_a = gpio_in_o[7:0]; dev_pr = 1'b1; dstate = 1; end
          1: if (!gpio_in_o[9]) begin dev_pr = 1'b0; dstate = 2; end
          2: if (gpio_in_o[9]) begin dev_b = gpio_in_o[7:0]; dev_pr = 1'b1; dstate = 3; end
          3: if (!gpio_in_o[9]) begin
               dev_pr = 1'b0; dev_cur = dev_a;
               dstate = (dev_b > dev_a) ? 4 : 0;
             end
          4: begin dev_data = dev_cur; dev_pw = 1'b1; dstate = 5; end
          5: if (gpio_in_o[8]) begin dev_pw = 1'b0; dstate = 6; end
          6: if (!gpio_in_o[8]) begin
               dev_cur = dev_cur + 8'd1;
               dstate = (dev_cur == dev_b) ? 0 : 4;
             end
          default: dstate = 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [7:0] s, input logic [7:0] e);
    chk("cmd_ready before issue", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_start = s; cmd_end = e;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 3000) begin @(negedge clk); n++; end
    chk(tag, {31'd0, busy}, 32'd0);
    @(negedge clk);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    int n = 0;
    while (rd_valid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    chk(tag, {23'd0, rd_valid, rd_data}, {23'd1, exp});
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    int d0;
    int rflk_hits;
    int n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_start = 8'd0; cmd_end = 8'd0;
    rd_en = 1'b0; dev_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset gpio_in_o", gpio_in_o, 32'd0);
    chk("reset rd_valid/rd_data", {23'd0, rd_valid, rd_data}, 32'd0);
    chk("reset busy/done/err/ready", {28'd0, busy, done, err, cmd_ready}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // start=3, end=7
    d0 = done_cnt;
    issue(8'd3, 8'd7);
    chk("send A drive", gpio_in_o, 32'h0000_0203);
    chk("busy after accept", {30'd0, busy, cmd_ready}, 32'h2);
    wait_idle("3..7 idle");
    chk("3..7 done pulses", done_cnt - d0, 32'd1);
    chk("3..7 device saw end", {24'd0, dev_b}, 32'd7);
    pop_expect("3..7 byte0", 8'd3);
    pop_expect("3..7 byte1", 8'd4);
    pop_expect("3..7 byte2", 8'd5);
    pop_expect("3..7 byte3", 8'd6);
    chk("3..7 fifo empty", {31'd0, rd_valid}, 32'd0);

    // start=end=5: handshakes only
    d0 = done_cnt;
    issue(8'd5, 8'd5);
    wait_idle("5..5 idle");
    chk("5..5 done pulses", done_cnt - d0, 32'd1);
    chk("5..5 no push", {31'd0, rd_valid}, 32'd0);
    chk("5..5 device handshakes", {16'd0, dev_a, dev_b}, 32'h0505);
    chk("5..5 gpio idle", gpio_in_o, 32'd0);

    // command while busy is ignored
    d0 = done_cnt;
    issue(8'd3, 8'd7);
    repeat (4) @(negedge clk);
    chk("busy blocks ready", {31'd0, cmd_ready}, 32'd0);
    cmd_valid = 1'b1; cmd_start = 8'd50; cmd_end = 8'd60;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle("ignore idle");
    chk("ignore done pulses", done_cnt - d0, 32'd1);
    pop_expect("ignore byte0", 8'd3);
    pop_expect("ignore byte1", 8'd4);
    pop_expect("ignore byte2", 8'd5);
    pop_expect("ignore byte3", 8'd6);
    chk("ignore fifo empty", {31'd0, rd_valid}, 32'd0);

    // 0..20 with FIFO backpressure
    d0 = done_cnt;
    issue(8'd0, 8'd20);
    repeat (400) @(negedge clk);
    rflk_hits = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (gpio_in_o[8] !== 1'b0) rflk_hits++;
    end
    chk("full read flicker low", rflk_hits, 32'd0);
    chk("full busy/err", {30'd0, busy, err}, 32'h2);
    chk("full head", {23'd0, rd_valid, rd_data}, 32'h100);
    for (int i = 0; i < 20; i++) begin
      pop_expect("drain byte", 8'(i));
    end
    wait_idle("drain idle");
    chk("drain done pulses", done_cnt - d0, 32'd1);
    chk("drain empty/err", {30'd0, rd_valid, err}, 32'd0);

    // silent device -> timeout after 100 cycles in SEND_A_HI
    dev_en = 1'b0;
    @(negedge clk);
    d0 = done_cnt;
    issue(8'd1, 8'd2);
    repeat (99) @(negedge clk);
    chk("timeout pre busy/err", {30'd0, busy, err}, 32'h2);
    @(negedge clk);
    chk("timeout busy/err", {30'd0, busy, err}, 32'h1);
    chk("timeout gpio", gpio_in_o, 32'd0);
    @(negedge clk);
    chk("timeout no done", done_cnt - d0, 32'd0);
    dev_en = 1'b1;
    @(negedge clk);
    issue(8'd8, 8'd9);
    chk("err cleared on accept", {31'd0, err}, 32'd0);
    wait_idle("after-timeout idle");
    pop_expect("after-timeout byte", 8'd8);
    chk("after-timeout err", {30'd0, rd_valid, err}, 32'd0);

    // reset while in RECV_ACK
    issue(8'd10, 8'd13);
    n = 0;
    while (gpio_in_o[8] !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    chk("reached RECV_ACK", {30'd0, gpio_in_o[8], rd_valid}, 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid reset gpio", gpio_in_o, 32'd0);
    chk("mid reset fifo", {23'd0, rd_valid, rd_data}, 32'd0);
    chk("mid reset busy/done/err", {29'd0, busy, done, err}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post reset quiet", {30'd0, rd_valid, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
